// File: rtl/uart_pkg.sv
// Shared UART definitions: frame constants, receiver FSM encoding and
// the even-parity helper used by both the receiver and the transmitter.
package uart_pkg;

    localparam int OVERSAMPLE = 16;  // ticks per bit
    localparam int DATA_BITS  = 8;   // payload bits, LSB first
    localparam int START_MID  = 8;   // tick at which the start bit is re-checked

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_WAIT_IDLE
    } rx_state_t;

    // Even parity: returns the bit that makes the total count of ones even.
    function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle tick every BAUD_DIV clocks.
// Clear holds the phase at zero so the first tick lands a fixed
// distance after the event that released it.
module uart_baud_tick #(
    parameter int BAUD_DIV = 27
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

    logic [CW-1:0] cnt;

    // Count 0..BAUD_DIV-1, wrapping; held at zero while cleared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = !clear && (cnt == LAST);

endmodule

// File: rtl/uart_rx_oversample.sv
// 16x-oversampling UART receiver: 1 start, 8 data (LSB first), even
// parity, 1 stop. Samples each bit at mid-bit, rejects false starts,
// holds the byte behind a valid/ready handshake and flags overruns.
module uart_rx_oversample
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = 27
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_in,
    output logic [7:0] rx_out,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       parity_error,
    output logic       stop_error,
    output logic       overrun
);

    localparam logic [3:0] SCNT_LAST  = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] START_LAST = 4'(START_MID - 1);
    localparam logic [2:0] IDX_LAST   = 3'(DATA_BITS - 1);

    logic                 sync1, rx_s;
    logic                 tick;
    rx_state_t            state, state_next;
    logic [3:0]           scnt, scnt_next;
    logic [2:0]           idx, idx_next;
    logic [DATA_BITS-1:0] shift, shift_next;
    logic                 perr, perr_next;
    logic                 deliver;

    // Two-flop synchronizer for the asynchronous line; resets to idle-high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            // NOTE: non-blocking so rx_s takes the pre-edge sync1, giving two real flop stages.
            sync1 <= rx_in;
            rx_s  <= sync1;
        end
    end

    // Tick phase restarts from zero whenever the receiver is idle.
    uart_baud_tick #(.BAUD_DIV(BAUD_DIV)) u_tick (
        .clk   (clk),
        .rst   (rst),
        .clear (state == ST_IDLE),
        .tick  (tick)
    );

    // FSM and bit-timing registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            scnt  <= '0;
            idx   <= '0;
            shift <= '0;
            perr  <= 1'b0;
        end else begin
            state <= state_next;
            scnt  <= scnt_next;
            idx   <= idx_next;
            shift <= shift_next;
            perr  <= perr_next;
        end
    end

    // Next-state logic: mid-bit sampling driven by the tick/scnt pair.
    always_comb begin
        // NOTE: every signal gets a default first so no branch leaves one unassigned and infers a latch.
        state_next = state;
        scnt_next  = scnt;
        idx_next   = idx;
        shift_next = shift;
        perr_next  = perr;
        deliver    = 1'b0;
        case (state)
            ST_IDLE: begin
                scnt_next = '0;
                if (!rx_s) state_next = ST_START;
            end
            ST_START: begin
                if (tick) begin
                    if (scnt == START_LAST) begin
                        // Mid start bit: still low means a real start.
                        scnt_next  = '0;
                        idx_next   = '0;
                        state_next = rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        scnt_next = scnt + 4'd1;
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    scnt_next = scnt + 4'd1;
                    if (scnt == SCNT_LAST) begin
                        shift_next[idx] = rx_s;
                        if (idx == IDX_LAST) state_next = ST_PARITY;
                        else                 idx_next   = idx + 3'd1;
                    end
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    scnt_next = scnt + 4'd1;
                    if (scnt == SCNT_LAST) begin
                        perr_next  = even_parity(shift) ^ rx_s;
                        state_next = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    scnt_next = scnt + 4'd1;
                    if (scnt == SCNT_LAST) begin
                        deliver    = 1'b1;
                        state_next = rx_s ? ST_IDLE : ST_WAIT_IDLE;
                    end
                end
            end
            ST_WAIT_IDLE: begin
                // A held-low line (break) must go high before a new start counts.
                if (rx_s) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Output holding register with valid/ready handshake and overrun pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_out       <= '0;
            rx_valid     <= 1'b0;
            parity_error <= 1'b0;
            stop_error   <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (deliver) begin
                if (!rx_valid || rx_ready) begin
                    rx_out       <= shift;
                    parity_error <= perr;
                    stop_error   <= ~rx_s;
                    rx_valid     <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule
